// File: rtl/spu_mc_ctl.sv
// spu_mc_ctl: serves one packet-id request channel at a time, sequencing
// head flit, data flits and packet-buffer drain, with timeout and routing
// error detection.
// Optional feature: define SPU_MC_PKT_CNT_EN to add the pkt_cnt output and
// its completed-packet counter.
module spu_mc_ctl #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CW         = 16,
  parameter int unsigned WR_BUF_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NCH-1:0]           spidr_vld,
  input  logic [NCH-1:0]           sprr_vld,
  input  logic                     retire_keep,
  input  logic [CW-1:0]            cfg_pkt_req_dly,
  input  logic [CW-1:0]            cfg_snd_flt_dly,
  output logic                     sel_od,
  output logic                     head_flt_vld,
  output logic                     data_flt_vld,
  output logic                     rd_pb_en,
  output logic                     start_read_sram,
  input  logic                     od_vld,
  input  logic                     od_rdy,
  input  logic                     pb_empty,
  input  logic                     read_sram_done,
  input  logic                     read_sram_err,
  output logic [$clog2(NCH)-1:0]   ch_sel,
  output logic                     ch_busy,
  output logic                     err_vld,
  output logic [2:0]               err_code,
  output logic [$clog2(NCH)-1:0]   err_ch
`ifdef SPU_MC_PKT_CNT_EN
  ,
  output logic [31:0]              pkt_cnt
`endif
);

  localparam int unsigned CHW = $clog2(NCH);
  localparam int unsigned DCW = 3;
  localparam int unsigned NS  = 6;

  // One-hot state bit positions
  localparam int unsigned I_IDLE  = 0;
  localparam int unsigned I_SPID  = 1;
  localparam int unsigned I_SHF   = 2;
  localparam int unsigned I_SDF   = 3;
  localparam int unsigned I_DRAIN = 4;
  localparam int unsigned I_ERR   = 5;

  localparam logic [NS-1:0] ST_IDLE  = 6'b000001;
  localparam logic [NS-1:0] ST_SPID  = 6'b000010;
  localparam logic [NS-1:0] ST_SHF   = 6'b000100;
  localparam logic [NS-1:0] ST_SDF   = 6'b001000;
  localparam logic [NS-1:0] ST_DRAIN = 6'b010000;
  localparam logic [NS-1:0] ST_ERR   = 6'b100000;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_MISS     = 3'd1;
  localparam logic [2:0] ERR_PKT_TMO  = 3'd2;
  localparam logic [2:0] ERR_HEAD_TMO = 3'd3;
  localparam logic [2:0] ERR_DATA_TMO = 3'd4;
  localparam logic [2:0] ERR_SRAM     = 3'd5;

  logic [NS-1:0]  state_q;
  logic [NS-1:0]  state_d;
  logic [CHW-1:0] last_gnt_q;
  logic [CW-1:0]  tick_q;
  logic [CW-1:0]  tick_inc;
  logic [DCW-1:0] dcnt_q;
  logic           gnt_found;
  logic [CHW-1:0] gnt_idx;
  logic [CHW-1:0] rr_idx;
  logic           mr_found;
  logic [CHW-1:0] mr_idx;
  logic           stall_st;
  logic           state_chg;
  logic           drain_done;
  logic           enter_err;
  logic [2:0]     err_code_d;
  logic [CHW-1:0] err_ch_d;

  assign stall_st   = state_q[I_SHF] | state_q[I_SDF] | state_q[I_DRAIN];
  assign state_chg  = (state_d != state_q);
  assign tick_inc   = (&tick_q) ? tick_q : tick_q + CW'(1);
  assign drain_done = pb_empty && (dcnt_q == DCW'(WR_BUF_LAT - 1));
  assign enter_err  = state_d[I_ERR] & ~state_q[I_ERR];

  // Round-robin grant search starting one past the last granted channel
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_idx    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      rr_idx = CHW'((32'(last_gnt_q) + 32'd1 + i) % NCH);
      if (!gnt_found && spidr_vld[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx;
      end
    end
  end

  // Lowest-index routing response seen while idle (miss-route source)
  always_comb begin
    mr_found = 1'b0;
    mr_idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!mr_found && sprr_vld[CHW'(i)]) begin
        mr_found = 1'b1;
        mr_idx   = CHW'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, plus the error status to load when entering ERROR
  always_comb begin
    state_d    = state_q;
    err_code_d = ERR_NONE;
    err_ch_d   = ch_sel;
    case (1'b1)
      state_q[I_IDLE]: begin
        if (gnt_found) begin
          state_d = ST_SPID;
        end else if (mr_found) begin
          state_d    = ST_ERR;
          err_code_d = ERR_MISS;
          err_ch_d   = mr_idx;
        end
      end
      state_q[I_SPID]: begin
        if (sprr_vld[ch_sel]) begin
          state_d = ST_SHF;
        end else if (tick_q > cfg_pkt_req_dly) begin
          state_d    = ST_ERR;
          err_code_d = ERR_PKT_TMO;
        end
      end
      state_q[I_SHF]: begin
        if (od_rdy) begin
          state_d = ST_SDF;
        end else if (tick_q > cfg_snd_flt_dly) begin
          state_d    = ST_ERR;
          err_code_d = ERR_HEAD_TMO;
        end
      end
      state_q[I_SDF]: begin
        if (read_sram_done) begin
          state_d = ST_DRAIN;
        end else if (read_sram_err) begin
          state_d    = ST_ERR;
          err_code_d = ERR_SRAM;
        end else if (tick_q > cfg_snd_flt_dly) begin
          state_d    = ST_ERR;
          err_code_d = ERR_DATA_TMO;
        end
      end
      state_q[I_DRAIN]: begin
        if (drain_done) begin
          state_d = ST_IDLE;
        end else if (read_sram_err) begin
          state_d    = ST_ERR;
          err_code_d = ERR_SRAM;
        end else if (tick_q > cfg_snd_flt_dly) begin
          state_d    = ST_ERR;
          err_code_d = ERR_DATA_TMO;
        end
      end
      state_q[I_ERR]: begin
        if (!retire_keep) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    sel_od          = 1'b0;
    head_flt_vld    = 1'b0;
    data_flt_vld    = 1'b0;
    rd_pb_en        = 1'b0;
    start_read_sram = 1'b0;
    ch_busy         = 1'b0;
    if (state_q[I_SPID]) begin
      ch_busy = 1'b1;
    end
    if (state_q[I_SHF]) begin
      ch_busy         = 1'b1;
      start_read_sram = 1'b1;
      head_flt_vld    = 1'b1;
    end
    if (state_q[I_SDF] | state_q[I_DRAIN]) begin
      ch_busy      = 1'b1;
      sel_od       = 1'b1;
      data_flt_vld = ~pb_empty;
      rd_pb_en     = od_vld & od_rdy;
    end
  end

  // Granted channel and round-robin pointer, updated on each new grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch_sel     <= '0;
      last_gnt_q <= CHW'(NCH - 1);
    end else if (state_q[I_IDLE] && gnt_found) begin
      ch_sel     <= gnt_idx;
      last_gnt_q <= gnt_idx;
    end
  end

  // Timeout tick: free-running in SPID, consecutive stalls elsewhere
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_q <= '0;
    end else if (state_chg) begin
      tick_q <= '0;
    end else if (state_q[I_SPID]) begin
      tick_q <= tick_inc;
    end else if (stall_st) begin
      tick_q <= (od_vld & ~od_rdy) ? tick_inc : '0;
    end else begin
      tick_q <= '0;
    end
  end

  // Consecutive pb_empty cycles while draining the packet buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dcnt_q <= '0;
    end else if (state_chg || !state_q[I_DRAIN] || !pb_empty) begin
      dcnt_q <= '0;
    end else if (dcnt_q < DCW'(WR_BUF_LAT - 1)) begin
      dcnt_q <= dcnt_q + DCW'(1);
    end
  end

  // Error status: loads entering ERROR, clears when ERROR retires
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_vld  <= 1'b0;
      err_code <= ERR_NONE;
      err_ch   <= '0;
    end else if (enter_err) begin
      err_vld  <= 1'b1;
      err_code <= err_code_d;
      err_ch   <= err_ch_d;
    end else if (state_q[I_ERR] && !retire_keep) begin
      err_vld  <= 1'b0;
      err_code <= ERR_NONE;
      err_ch   <= '0;
    end
  end

`ifdef SPU_MC_PKT_CNT_EN
  // Completed packets, counted on each DRAIN to IDLE hand-back
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt <= '0;
    end else if (state_q[I_DRAIN] && state_d[I_IDLE]) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end
`endif

endmodule
